// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register peripheral: frame geometry,
// register map and the receive state machine encoding.
package spi_pkg;

    localparam int FRAME_BITS = 16;

    // Register map (7-bit address field of the frame)
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    // Bit counter stops here so over-long frames stay distinguishable
    localparam logic [4:0] CNT_SAT = 5'd17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_e;

    // True when the address falls inside the implemented register window
    function automatic logic addr_valid(input logic [6:0] addr, input logic [6:0] max_addr);
        return (addr <= max_addr);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for one asynchronous input bit. The reset level
// is supplied as an input so each SPI line can park at its idle value.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_r;

    // Shift the asynchronous input through DEPTH flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= {DEPTH{rst_val}};
        end else begin
            stage_r <= {stage_r[DEPTH-2:0], d};
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral exposing five 8-bit control registers to the PWM
// stage. Frames are {rw, addr[6:0], data[7:0]}, MSB first, rw=1 writes.
// Optional readback of rw=0 frames on cipo is enabled by SPI_READBACK_EN.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [1:0] FLUSH_DONE = 2'(SYNC_STAGES);

    logic       sclk_sync_s;
    logic       copi_sync_s;
    logic       ncs_sync_s;
    logic       sclk_prev_r;
    logic       ncs_prev_r;
    logic [1:0] flush_cnt_r;
    logic       armed_r;
    logic       sclk_rise_s;
    logic       ncs_fall_s;
    logic       ncs_rise_s;
    logic       write_en_s;

    spi_state_e  state_r;
    spi_state_e  state_next_s;
    logic [4:0]  cnt_r;
    logic [15:0] shift_r;

    logic [7:0] reg_out_lo_r;
    logic [7:0] reg_out_hi_r;
    logic [7:0] reg_pwm_lo_r;
    logic [7:0] reg_pwm_hi_r;
    logic [7:0] reg_duty_r;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .rst_val(1'b0), .d(sclk), .q(sclk_sync_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .rst_val(1'b0), .d(copi), .q(copi_sync_s)
    );
    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .rst_val(1'b1), .d(ncs), .q(ncs_sync_s)
    );

    // Previous synchronized levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_r <= 1'b0;
            ncs_prev_r  <= 1'b1;
        end else begin
            sclk_prev_r <= sclk_sync_s;
            ncs_prev_r  <= ncs_sync_s;
        end
    end

    // Count clocks after reset until the synchronizers hold real samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= 2'd0;
        end else if (flush_cnt_r != FLUSH_DONE) begin
            flush_cnt_r <= flush_cnt_r + 2'd1;
        end
    end

    // Arm frame start only once ncs has really been seen high after reset,
    // so a frame interrupted by reset cannot resume mid-way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 1'b0;
        end else if ((flush_cnt_r == FLUSH_DONE) && ncs_sync_s) begin
            armed_r <= 1'b1;
        end
    end

    assign sclk_rise_s = sclk_sync_s & ~sclk_prev_r;
    assign ncs_fall_s  = armed_r & ncs_prev_r & ~ncs_sync_s;
    assign ncs_rise_s  = ~ncs_prev_r & ncs_sync_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and commit qualification
    always_comb begin
        state_next_s = state_r;
        write_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ncs_fall_s) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (ncs_rise_s) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            COMMIT: begin
                state_next_s = IDLE;
                write_en_s   = (cnt_r == 5'(FRAME_BITS)) && shift_r[15] &&
                               addr_valid(shift_r[14:8], MAX_ADDR);
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Bit counter and receive shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 5'd0;
            shift_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ncs_fall_s) begin
                        cnt_r   <= 5'd0;
                        shift_r <= 16'h0000;
                    end
                end
                SHIFT: begin
                    if (sclk_rise_s) begin
                        shift_r <= {shift_r[14:0], copi_sync_s};
                        if (cnt_r != CNT_SAT) begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file update on a qualified write frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_out_lo_r <= 8'h00;
            reg_out_hi_r <= 8'h00;
            reg_pwm_lo_r <= 8'h00;
            reg_pwm_hi_r <= 8'h00;
            reg_duty_r   <= 8'h00;
        end else if (write_en_s) begin
            case (shift_r[14:8])
                ADDR_EN_OUT_7_0:  reg_out_lo_r <= shift_r[7:0];
                ADDR_EN_OUT_15_8: reg_out_hi_r <= shift_r[7:0];
                ADDR_EN_PWM_7_0:  reg_pwm_lo_r <= shift_r[7:0];
                ADDR_EN_PWM_15_8: reg_pwm_hi_r <= shift_r[7:0];
                ADDR_PWM_DUTY:    reg_duty_r   <= shift_r[7:0];
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = reg_out_lo_r;
    assign en_reg_out_15_8 = reg_out_hi_r;
    assign en_reg_pwm_7_0  = reg_pwm_lo_r;
    assign en_reg_pwm_15_8 = reg_pwm_hi_r;
    assign pwm_duty_cycle  = reg_duty_r;

`ifdef SPI_READBACK_EN
    logic       sclk_fall_s;
    logic [7:0] rd_val_s;
    logic [6:0] rd_shift_r;
    logic       cipo_r;

    assign sclk_fall_s = ~sclk_sync_s & sclk_prev_r;

    // Select readback byte once rw and address (first 8 bits) are in
    always_comb begin
        rd_val_s = 8'h00;
        if (!shift_r[7] && addr_valid(shift_r[6:0], MAX_ADDR)) begin
            case (shift_r[6:0])
                ADDR_EN_OUT_7_0:  rd_val_s = reg_out_lo_r;
                ADDR_EN_OUT_15_8: rd_val_s = reg_out_hi_r;
                ADDR_EN_PWM_7_0:  rd_val_s = reg_pwm_lo_r;
                ADDR_EN_PWM_15_8: rd_val_s = reg_pwm_hi_r;
                ADDR_PWM_DUTY:    rd_val_s = reg_duty_r;
                default:          rd_val_s = 8'h00;
            endcase
        end else begin
            rd_val_s = 8'h00;
        end
    end

    // Drive readback bits on falling edges, MSB after the 8th rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo_r     <= 1'b0;
            rd_shift_r <= 7'h00;
        end else if (state_r != SHIFT) begin
            cipo_r     <= 1'b0;
            rd_shift_r <= 7'h00;
        end else if (sclk_fall_s) begin
            if (cnt_r == 5'd8) begin
                cipo_r     <= rd_val_s[7];
                rd_shift_r <= rd_val_s[6:0];
            end else if ((cnt_r > 5'd8) && (cnt_r < 5'd16)) begin
                cipo_r     <= rd_shift_r[6];
                rd_shift_r <= {rd_shift_r[5:0], 1'b0};
            end
        end
    end

    assign cipo = cipo_r;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Randomized scoreboard bench for spi_peripheral: a register-map model
// predicts register contents and cipo read data for each frame.
module tb_spi_peripheral;

    localparam int SYNC = 2;
    localparam int CLK  = 10;
    localparam int HP   = 6;   // SPI half period / gaps in clk cycles

    logic clk = 1'b0;
    logic rst_n, sclk, copi, ncs;
    logic cipo;
    logic [7:0] r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;

    always #5 clk = ~clk;

    spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo),
        .en_reg_out_7_0(r_out_lo), .en_reg_out_15_8(r_out_hi),
        .en_reg_pwm_7_0(r_pwm_lo), .en_reg_pwm_15_8(r_pwm_hi),
        .pwm_duty_cycle(r_duty)
    );

    typedef struct {
        time         t;
        logic [39:0] regs;
        int          id;
    } reg_exp_t;

    reg_exp_t    reg_q[$];
    logic [15:0] cipo_q[$];
    logic [7:0]  model [5];
    int          checks;
    int          errors;
    int          exp_id;

    wire [39:0] dut_regs = {r_duty, r_pwm_hi, r_pwm_lo, r_out_hi, r_out_lo};

    function automatic logic [39:0] model_vec();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    task automatic push_regs(input int delay);
        reg_exp_t e;
        e.t    = $time + delay;
        e.regs = model_vec();
        e.id   = exp_id;
        exp_id++;
        reg_q.push_back(e);
    endtask

    task automatic spi_bits(input logic [31:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = word[i];
            repeat (HP) @(negedge clk);
            sclk = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic idle_toggles(input int n);
        for (int i = 0; i < n; i++) begin
            copi = 1'($urandom_range(0, 1));
            sclk = 1'b1;
            repeat (HP) @(negedge clk);
            sclk = 1'b0;
            repeat (HP) @(negedge clk);
        end
        copi = 1'b0;
    endtask

    task automatic frame(input logic [15:0] f, input int nbits);
        logic [6:0] a;
        logic [7:0] rd;
        a  = f[14:8];
        rd = 8'h00;
`ifdef SPI_READBACK_EN
        if (!f[15] && a <= 7'h04) rd = model[a[2:0]];
`endif
        if (nbits == 16) cipo_q.push_back({8'h00, rd});
        @(negedge clk);
        ncs = 1'b0;
        repeat (HP) @(negedge clk);
        if (nbits == 16)      spi_bits({16'h0000, f}, 16);
        else if (nbits == 15) spi_bits({17'h00000, f[15:1]}, 15);
        else                  spi_bits({15'h0000, f, 1'b1}, 17);
        repeat (HP) @(negedge clk);
        ncs  = 1'b1;
        copi = 1'b0;
        if (nbits == 16 && f[15] && a <= 7'h04) model[a[2:0]] = f[7:0];
        push_regs((SYNC + 2) * CLK);
        repeat (SYNC + 6) @(negedge clk);
    endtask

    // Register monitor: compare outputs at each expectation's deadline
    initial begin : reg_mon
        reg_exp_t e;
        forever begin
            wait (reg_q.size() != 0);
            e = reg_q.pop_front();
            if (e.t > $time) #(e.t - $time);
            checks++;
            if (dut_regs !== e.regs) begin
                errors++;
                $display("FAIL regs id=%0d got %h want %h", e.id, dut_regs, e.regs);
            end
        end
    end

    // cipo monitor: capture cipo on each sclk rise of a 16-bit frame
    initial begin : cipo_mon
        logic        ps, pn;
        int          bcnt;
        logic [15:0] cap, want;
        ps = 1'b0; pn = 1'b1; bcnt = 0; cap = 16'h0000;
        forever begin
            @(sclk or ncs or rst_n);
            if (rst_n !== 1'b1) begin
                bcnt = 99;
            end else if (ncs === 1'b0 && pn === 1'b1) begin
                bcnt = 0;
                cap  = 16'h0000;
            end else if (ncs === 1'b1 && pn === 1'b0) begin
                if (bcnt == 16) begin
                    checks++;
                    if (cipo_q.size() == 0) begin
                        errors++;
                        $display("FAIL cipo_unexpected got %h want none", cap);
                    end else begin
                        want = cipo_q.pop_front();
                        if (cap !== want) begin
                            errors++;
                            $display("FAIL cipo_read got %h want %h", cap, want);
                        end
                    end
                end
            end else if (sclk === 1'b1 && ps === 1'b0 && ncs === 1'b0) begin
                cap = {cap[14:0], cipo};
                bcnt++;
            end
            ps = sclk;
            pn = ncs;
        end
    end

    initial begin : stim
        logic [15:0] f;
        int nb;
        checks = 0; errors = 0; exp_id = 0;
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        push_regs(0);
        checks++;
        if (cipo !== 1'b0) begin
            errors++;
            $display("FAIL reset_cipo got %b want 0", cipo);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed frames: valid writes, out-of-range, bad lengths
        frame(16'h80F0, 16);
        frame(16'h8480, 16);
        frame(16'h85AA, 16);
        frame(16'h8155, 15);
        frame(16'h8155, 17);
        frame(16'h8255, 16);

        // Reset mid-frame with ncs still low across release
        @(negedge clk);
        ncs = 1'b0;
        repeat (HP) @(negedge clk);
        spi_bits(32'h0000_0082, 8);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        push_regs(CLK);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        spi_bits(32'h0000_00FF, 8);
        repeat (HP) @(negedge clk);
        ncs  = 1'b1;
        copi = 1'b0;
        push_regs((SYNC + 2) * CLK);
        repeat (SYNC + 6) @(negedge clk);
        frame(16'h8233, 16);

        // Readback and idle-sclk cases
        frame(16'h83C3, 16);
        frame(16'h0300, 16);
        frame(16'h0500, 16);
        idle_toggles(16);
        frame(16'h8011, 16);

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            f[15]   = ($urandom_range(0, 3) != 0);
            f[14:8] = 7'($urandom_range(0, 7));
            f[7:0]  = 8'($urandom);
            if ($urandom_range(0, 9) == 0) nb = ($urandom_range(0, 1) != 0) ? 15 : 17;
            else nb = 16;
            frame(f, nb);
            if ($urandom_range(0, 3) == 0) idle_toggles($urandom_range(1, 4));
        end

        // Drain outstanding expectations with a bounded wait
        for (int i = 0; i < 200 && (reg_q.size() != 0); i++) @(negedge clk);
        if (reg_q.size() != 0 || cipo_q.size() != 0) begin
            errors++;
            $display("FAIL drain got reg_q=%0d cipo_q=%0d want 0 0", reg_q.size(), cipo_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer, legal values 2..3.
REQ-002 Parameter MAX_ADDR, default 7'h04: highest valid register address.
REQ-003 Port clk, input, 1: single system clock; every flop in the block is on clk.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port sclk, input, 1: SPI serial clock, asynchronous to clk.
REQ-006 Port copi, input, 1: SPI controller-out/peripheral-in data, asynchronous to clk.
REQ-007 Port ncs, input, 1: SPI chip select, active-low, asynchronous to clk.
REQ-008 Port cipo, output, 1: SPI peripheral-out/controller-in data.
REQ-009 Ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle: outputs, 8 bits each, registers 0x00..0x04 driven directly to the PWM stage.

Function
REQ-010 sclk, copi and ncs SHALL each pass through a SYNC_STAGES-deep synchronizer; all edge detection SHALL use the synchronized copies.
REQ-011 SPI mode 0: copi sampled on detected sclk rising edge; cipo changes on detected sclk falling edge; MSB first.
REQ-012 Frame: 16 bits = {rw[15], addr[14:8], data[7:0]}; rw=1 is write.
REQ-013 FSM states: IDLE, SHIFT, COMMIT.
REQ-014 IDLE->SHIFT on synchronized ncs falling edge; bit counter and shift register cleared.
REQ-015 SHIFT: each sclk rising edge shifts one bit in; the 5-bit counter saturates at 17.
REQ-016 SHIFT->COMMIT on synchronized ncs rising edge; COMMIT->IDLE unconditionally after one clk.
REQ-017 In COMMIT, write SHALL occur only if count==16, rw==1 and addr<=MAX_ADDR; otherwise the frame is discarded with no register change.
REQ-018 Register update SHALL be visible on outputs no more than SYNC_STAGES+2 clk cycles after the physical ncs rising edge.
REQ-019 sclk edges while ncs is high SHALL be ignored.
REQ-020 Timing constraint: every sclk high and low phase, and ncs high time between frames, SHALL be at least SYNC_STAGES+2 clk periods; behaviour outside this is undefined.
REQ-021 cipo SHALL be 0 outside SHIFT and whenever the readback feature is absent.

Reset
REQ-022 rst_n low SHALL force FSM to IDLE, counter and shift register to 0, all five registers to 8'h00, cipo to 0, and synchronizers to the idle levels (sclk 0, ncs 1, copi 0).
REQ-023 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh ncs falling edge.

Configuration
REQ-024 Macro SPI_READBACK_EN defined: rw==0 frames are reads; after the 8th rising edge, if addr<=MAX_ADDR, cipo SHALL present bit 7 of the addressed register, then the next lower bit on each following falling edge; invalid address reads SHALL return 8'h00.
REQ-025 Macro SPI_READBACK_EN undefined: rw==0 frames are discarded, cipo tied 0, and no readback logic is synthesized.

Structure
REQ-026 Shared package spi_pkg SHALL hold FRAME_BITS=16, address constants ADDR_EN_OUT_7_0..ADDR_PWM_DUTY (0x00..0x04), and the FSM state enum.
REQ-027 One sub-module, sync_ff (parameterized depth, reset value input), SHALL implement each synchronizer; all other logic lives in spi_peripheral.

Verification
REQ-028 Write frame 0x80F0 (addr 0x00, data 0xF0) -> en_reg_out_7_0==0xF0 within 4 clk after ncs rise; other registers unchanged at 0x00.
REQ-029 Write frame 0x8480 (addr 0x04) -> pwm_duty_cycle==0x80; write 0x85AA (addr 0x05) -> no register changes.
REQ-030 Frame with 15 bits, and a frame with 17 bits, each carrying 0x8155 -> en_reg_out_15_8 stays 0x00.
REQ-031 Write 0x8255, then assert rst_n low mid-way through write 0x82FF -> en_reg_pwm_7_0==0x00 after reset; a subsequent clean 0x8233 write yields 0x33.
REQ-032 With SPI_READBACK_EN: write 0x83C3, then read 0x0300 -> cipo bits sampled on sclk rising edges 9..16 equal 0xC3; without the macro, cipo stays 0 throughout.
REQ-033 sclk toggled 16 times with ncs high, then valid write 0x8011 -> only 0x11 lands in en_reg_out_7_0.
